// File: rtl/fifo_rd_serializer_if.sv
// fifo_rd_serializer_if: upstream FIFO read port and downstream byte stream of fifo_rd_serializer.
// The byte_par signal exists only when FIFO_RD_SER_PARITY_EN is defined.
interface fifo_rd_serializer_if;
    logic [15:0] fifo_dout;
    logic        fifo_emptyp;
    logic        fifo_readp;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
`ifdef FIFO_RD_SER_PARITY_EN
    logic        byte_par;
`endif
    modport master (
        input  fifo_dout, fifo_emptyp, byte_ready,
        output fifo_readp, byte_out, byte_valid, busy
`ifdef FIFO_RD_SER_PARITY_EN
        , output byte_par
`endif
    );
    modport slave (
        output fifo_dout, fifo_emptyp, byte_ready,
        input  fifo_readp, byte_out, byte_valid, busy
`ifdef FIFO_RD_SER_PARITY_EN
        , input byte_par
`endif
    );
endinterface

// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: reads 16-bit words from a latency-1 sync FIFO and emits them as a byte stream.
// Defining FIFO_RD_SER_PARITY_EN adds an even-parity output byte_par alongside byte_out.
module fifo_rd_serializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  rstp,
    fifo_rd_serializer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, FIRST, SECOND} state_t;
    state_t      state, state_d;
    logic [15:0] word, word_d, pend, pend_d;
    logic        pend_v, pend_v_d, pf, pf_d, rd;
    logic [7:0]  first_b, second_b;
    assign first_b        = MSB_FIRST ? word[15:8] : word[7:0];
    assign second_b       = MSB_FIRST ? word[7:0] : word[15:8];
    assign bus.byte_valid = (state == FIRST) || (state == SECOND);
    assign bus.byte_out   = state == FIRST ? first_b : state == SECOND ? second_b : 8'h00;
    assign bus.busy       = (state != IDLE) || pend_v;
    assign bus.fifo_readp = rstp && rd;
`ifdef FIFO_RD_SER_PARITY_EN
    assign bus.byte_par   = ^bus.byte_out;
`endif
    // next state, word/pending loads and FIFO read strobe; pf marks a prefetch whose data lands next cycle
    always_comb begin
        state_d  = state;
        word_d   = word;
        pend_d   = pend;
        pend_v_d = pend_v;
        pf_d     = 1'b0;
        rd       = 1'b0;
        case (state)
            IDLE: begin
                rd      = !bus.fifo_emptyp;
                state_d = bus.fifo_emptyp ? IDLE : FETCH;
            end
            FETCH: begin
                word_d  = bus.fifo_dout;
                state_d = FIRST;
            end
            FIRST: begin
                if (bus.byte_ready) begin
                    state_d = SECOND;
                    rd      = !bus.fifo_emptyp && !pend_v;
                    pf_d    = !bus.fifo_emptyp && !pend_v;
                end
            end
            SECOND: begin
                if (bus.byte_ready) begin
                    if (pend_v) begin
                        word_d   = pend;
                        pend_v_d = 1'b0;
                        state_d  = FIRST;
                    end else if (pf) begin
                        word_d  = bus.fifo_dout;
                        state_d = FIRST;
                    end else begin
                        rd      = !bus.fifo_emptyp;
                        state_d = bus.fifo_emptyp ? IDLE : FETCH;
                    end
                end else if (pf) begin
                    pend_d   = bus.fifo_dout;
                    pend_v_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and data registers; reset discards any partial or prefetched word
    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            state  <= IDLE;
            word   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            pf     <= 1'b0;
        end else begin
            state  <= state_d;
            word   <= word_d;
            pend   <= pend_d;
            pend_v <= pend_v_d;
            pf     <= pf_d;
        end
    end
endmodule
